// File: rtl/mode_scheduler_pkg.sv
// Shared definitions for the six-mode panel sequencer: mode codes,
// scheduler state encoding and one-hot helper functions.
package mode_pkg;

  localparam logic [2:0] MODE_DEFAULT = 3'd0;
  localparam logic [2:0] MODE_STORE   = 3'd1;
  localparam logic [2:0] MODE_GEN     = 3'd2;
  localparam logic [2:0] MODE_SHOW    = 3'd3;
  localparam logic [2:0] MODE_CALC    = 3'd4;
  localparam logic [2:0] MODE_SETUP   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_EXIT  = 3'd3,
    ST_ERROR = 3'd4
  } sched_state_t;

  // Switch bit i selects mode code i+1; anything not one-hot maps to DEFAULT.
  function automatic logic [2:0] onehot_to_mode(input logic [4:0] v);
    logic [2:0] code;
    case (v)
      5'b00001: code = MODE_STORE;
      5'b00010: code = MODE_GEN;
      5'b00100: code = MODE_SHOW;
      5'b01000: code = MODE_CALC;
      5'b10000: code = MODE_SETUP;
      default:  code = MODE_DEFAULT;
    endcase
    return code;
  endfunction

  // True when exactly one of the five bits is set.
  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/mode_scheduler_if.sv
// Panel-side bundle between the scheduler, the mode engines and the
// display blocks. The scheduler uses the master view.
interface mode_scheduler_if;
  logic       btn_pulse;
  logic [4:0] mode_sw;
  logic [4:0] mode_done;
  logic [2:0] mode_state;
  logic [4:0] mode_start;
  logic       mode_abort;
  logic       busy;
  logic       error_active;
  logic       blink_bit;

  modport master (
    input  btn_pulse, mode_sw, mode_done,
    output mode_state, mode_start, mode_abort, busy, error_active, blink_bit
  );

  modport slave (
    output btn_pulse, mode_sw, mode_done,
    input  mode_state, mode_start, mode_abort, busy, error_active, blink_bit
  );
endinterface

// File: rtl/mode_scheduler_blink_timer.sv
// Error-phase timer: a start pulse launches ERR_BLINKS full blink periods of
// 2*HALF cycles each, blink beginning high. finished marks the last cycle.
module blink_timer #(
  parameter int HALF       = 1,
  parameter int ERR_BLINKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic active,
  output logic blink,
  output logic finished
);

  localparam int HALF_W = $clog2(HALF) + 1;
  localparam int PER_W  = $clog2(ERR_BLINKS) + 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(ERR_BLINKS - 1);

  logic [HALF_W-1:0] half_cnt_r;
  logic [PER_W-1:0]  per_cnt_r;
  logic              active_r;
  logic              blink_r;
  logic              half_end_s;
  logic              per_end_s;
  logic              finished_s;

  // Counter end detection; >= keeps the counters saturating rather than wrapping.
  always_comb begin
    half_end_s = (half_cnt_r >= HALF_LAST);
    per_end_s  = (per_cnt_r >= PER_LAST);
    finished_s = active_r & half_end_s & ~blink_r & per_end_s;
  end

  // Half-period and blink-period counters plus the blink waveform.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_r <= '0;
      per_cnt_r  <= '0;
      active_r   <= 1'b0;
      blink_r    <= 1'b0;
    end else if (start && !active_r) begin
      half_cnt_r <= '0;
      per_cnt_r  <= '0;
      active_r   <= 1'b1;
      blink_r    <= 1'b1;
    end else if (active_r) begin
      if (half_end_s) begin
        half_cnt_r <= '0;
        if (finished_s) begin
          active_r <= 1'b0;
          blink_r  <= 1'b0;
        end else begin
          blink_r <= ~blink_r;
          // A low half ending closes one full period.
          if (!blink_r && !per_end_s) begin
            per_cnt_r <= per_cnt_r + PER_W'(1);
          end
        end
      end else begin
        half_cnt_r <= half_cnt_r + HALF_W'(1);
      end
    end
  end

  assign active   = active_r;
  assign blink    = blink_r;
  assign finished = finished_s;

endmodule

// File: rtl/mode_scheduler.sv
// Central sequencer for the six-mode panel: grants one mode engine at a time
// with a start/done handshake, handles user abort and the error-blink phase.
module mode_scheduler
  import mode_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BLINK_HZ    = 4,
  parameter int ERR_BLINKS  = 3
) (
  input logic               clk,
  input logic               rst,
  mode_scheduler_if.master  bus
);

  localparam int HALF_RAW = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;

  sched_state_t state_r, next_state_s;
  logic [4:0]   sel_r, sel_next_s;
  logic         tmr_start_s, abort_next_s;
  logic         tmr_active_s, tmr_blink_s, tmr_finished_s;

  logic [2:0]   mode_state_r;
  logic [4:0]   mode_start_r;
  logic         mode_abort_r, busy_r, error_active_r, blink_bit_r;

  blink_timer #(.HALF(HALF), .ERR_BLINKS(ERR_BLINKS)) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start_s),
    .active   (tmr_active_s),
    .blink    (tmr_blink_s),
    .finished (tmr_finished_s)
  );

  // State and latched selection registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= 5'd0;
    end else begin
      state_r <= next_state_s;
      sel_r   <= sel_next_s;
    end
  end

  // Next-state decode, selection latch, error-timer launch and abort request.
  always_comb begin
    next_state_s = state_r;
    sel_next_s   = sel_r;
    tmr_start_s  = 1'b0;
    abort_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.btn_pulse) begin
          if (is_onehot5(bus.mode_sw)) begin
            sel_next_s   = bus.mode_sw;
            next_state_s = ST_START;
          end else begin
            tmr_start_s  = 1'b1;
            next_state_s = ST_ERROR;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: next_state_s = ST_RUN;
      ST_RUN: begin
        // Completion takes priority over a simultaneous abort request.
        if ((bus.mode_done & sel_r) != 5'd0) begin
          next_state_s = ST_EXIT;
        end else if (bus.btn_pulse && (bus.mode_sw == 5'd0)) begin
          abort_next_s = 1'b1;
          next_state_s = ST_EXIT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_EXIT: next_state_s = ST_IDLE;
      ST_ERROR: begin
        if (tmr_finished_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ERROR;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Registered outputs, each reflecting the state of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_state_r   <= MODE_DEFAULT;
      mode_start_r   <= 5'd0;
      mode_abort_r   <= 1'b0;
      busy_r         <= 1'b0;
      error_active_r <= 1'b0;
      blink_bit_r    <= 1'b0;
    end else begin
      mode_start_r   <= (state_r == ST_START) ? sel_r : 5'd0;
      mode_state_r   <= ((state_r == ST_START) || (state_r == ST_RUN)) ?
                        onehot_to_mode(sel_r) : MODE_DEFAULT;
      mode_abort_r   <= abort_next_s;
      busy_r         <= (state_r != ST_IDLE);
      error_active_r <= (state_r == ST_ERROR);
      blink_bit_r    <= (state_r == ST_ERROR) && tmr_active_s && tmr_blink_s;
    end
  end

  assign bus.mode_state   = mode_state_r;
  assign bus.mode_start   = mode_start_r;
  assign bus.mode_abort   = mode_abort_r;
  assign bus.busy         = busy_r;
  assign bus.error_active = error_active_r;
  assign bus.blink_bit    = blink_bit_r;

endmodule

// File: tb/tb_mode_scheduler.sv
// Directed scoreboard bench for mode_scheduler with HALF=4, 16-cycle error phase.
module tb_mode_scheduler;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] start;
    logic       abort;
    logic       busy;
    logic       err;
    logic       blink;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  exp_t  exp_q[$];
  string tag_q[$];

  mode_scheduler_if bus();

  mode_scheduler #(
    .CLK_FREQ_HZ (16),
    .BLINK_HZ    (2),
    .ERR_BLINKS  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [4:0] start,
                              input logic abort, input logic busy,
                              input logic err, input logic blink);
    exp_t e;
    e.st = st; e.start = start; e.abort = abort;
    e.busy = busy; e.err = err; e.blink = blink;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // compare after the edge.
  task automatic tick(input logic b, input logic [4:0] sw, input logic [4:0] dn,
                      input string tag, input exp_t e);
    exp_t  got;
    exp_t  want;
    string t;
    bus.btn_pulse = b;
    bus.mode_sw   = sw;
    bus.mode_done = dn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got  = {bus.mode_state, bus.mode_start, bus.mode_abort,
            bus.busy, bus.error_active, bus.blink_bit};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    tests++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s: got st=%0d start=%b abort=%b busy=%b err=%b blink=%b, expected st=%0d start=%b abort=%b busy=%b err=%b blink=%b",
             t, got.st, got.start, got.abort, got.busy, got.err, got.blink,
             want.st, want.start, want.abort, want.busy, want.err, want.blink);
    end
  endtask

  initial begin
    exp_t z;
    exp_t bl1;
    exp_t bl0;
    tests  = 0;
    failed = 0;
    z   = mk(3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    bl1 = mk(3'd0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b1);
    bl0 = mk(3'd0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    bus.btn_pulse = 1'b0;
    bus.mode_sw   = 5'b00000;
    bus.mode_done = 5'b00000;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) tick(1'b0, 5'b00000, 5'b00000, "reset", z);
    rst = 1'b0;
    tick(1'b0, 5'b00000, 5'b00000, "idle", z);

    // Valid grant of SHOW (00100 -> code 3).
    tick(1'b1, 5'b00100, 5'b00000, "grant_start_state", z);
    tick(1'b0, 5'b00100, 5'b00000, "grant_start_pulse", mk(3'd3, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00100, 5'b00000, "grant_run1", mk(3'd3, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00100, 5'b00000, "grant_run2", mk(3'd3, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00100, 5'b00000, "grant_run3", mk(3'd3, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00100, 5'b00100, "grant_done", mk(3'd3, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    // Button pulse sampled during EXIT must be dropped.
    tick(1'b1, 5'b00100, 5'b00000, "grant_exit", mk(3'd0, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00000, 5'b00000, "grant_idle", z);
    tick(1'b0, 5'b00000, 5'b00000, "exit_btn_dropped", z);

    // Abort of CALC (01000 -> code 4).
    tick(1'b1, 5'b01000, 5'b00000, "abort_grant", z);
    tick(1'b0, 5'b01000, 5'b00000, "abort_start", mk(3'd4, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b01000, 5'b00000, "abort_run", mk(3'd4, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b1, 5'b00000, 5'b00000, "abort_pulse", mk(3'd4, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00000, 5'b00000, "abort_exit", mk(3'd0, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00000, 5'b00000, "abort_idle", z);

    // Abort request together with done: done wins, no abort pulse.
    tick(1'b1, 5'b01000, 5'b00000, "race_grant", z);
    tick(1'b0, 5'b01000, 5'b00000, "race_start", mk(3'd4, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b01000, 5'b00000, "race_run", mk(3'd4, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b1, 5'b00000, 5'b01000, "race_no_abort", mk(3'd4, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00000, 5'b00000, "race_exit", mk(3'd0, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00000, 5'b00000, "race_idle", z);

    // Invalid multi-hot select: 16-cycle blink phase, extra pulses ignored.
    tick(1'b1, 5'b00011, 5'b00000, "err_enter", z);
    for (int i = 0; i < 16; i++) begin
      tick((i == 3 || i == 9 || i == 15) ? 1'b1 : 1'b0, 5'b00001, 5'b00000,
           $sformatf("err_blink%0d", i), ((i / 4) % 2 == 0) ? bl1 : bl0);
    end
    tick(1'b0, 5'b00000, 5'b00000, "err_done", z);
    tick(1'b0, 5'b00000, 5'b00000, "err_idle", z);

    // Foreign done and switch change while SETUP (10000 -> code 5) runs.
    tick(1'b1, 5'b10000, 5'b00000, "setup_grant", z);
    tick(1'b0, 5'b10000, 5'b00000, "setup_start", mk(3'd5, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00001, 5'b00001, "foreign_done", mk(3'd5, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b1, 5'b00001, 5'b01111, "foreign_btn", mk(3'd5, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 5'b00001, 5'b00000, "still_run", mk(3'd5, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0));

    // Reset mid-RUN, with an abort request present: no abort pulse.
    rst = 1'b1;
    tick(1'b1, 5'b00000, 5'b00000, "rst_run", z);
    rst = 1'b0;
    tick(1'b0, 5'b00000, 5'b00000, "rst_run_idle", z);

    // Reset mid-ERROR.
    tick(1'b1, 5'b00000, 5'b00000, "err2_enter", z);
    tick(1'b0, 5'b00000, 5'b00000, "err2_blink", bl1);
    tick(1'b0, 5'b00000, 5'b00000, "err2_blink_b", bl1);
    rst = 1'b1;
    tick(1'b0, 5'b00000, 5'b00000, "rst_err", z);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 5'b00000, 5'b00000, "rst_err_idle", z);

    // Recovery: STORE grant works after reset.
    tick(1'b1, 5'b00001, 5'b00000, "store_grant", z);
    tick(1'b0, 5'b00000, 5'b00000, "store_start", mk(3'd1, 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
